// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, LCR word-length codes, parity helper.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    // Receiver frame states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Baud ticks per bit unless overridden.
    localparam int OVS_DEFAULT = 16;

    // LCR word-length-select codes.
    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Number of data bits selected by an LCR wls code.
    function automatic logic [3:0] data_bits(input logic [1:0] wls);
        logic [3:0] n;
        case (wls)
            WLS_5:   n = 4'd5;
            WLS_6:   n = 4'd6;
            WLS_7:   n = 4'd7;
            WLS_8:   n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // Value the parity bit must carry for the given character.
    // Stick parity forces the bit to ~eps; otherwise even (eps=1) or odd
    // (eps=0) parity over the low nbits of data.
    function automatic logic parity_expected(
        input logic [7:0] data,
        input logic [3:0] nbits,
        input logic       eps,
        input logic       sp
    );
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nbits)) begin
                acc = acc ^ data[i];
            end
        end
        if (sp) begin
            return ~eps;
        end
        return eps ? acc : ~acc;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: baud tick, serial line, LCR fields and the FIFO push port.
// Latency: n/a (wires only).
// Backpressure: none; the push port is a fire-and-forget strobe into the receive FIFO.
//
// master: drives baud_pulse, rx and LCR fields; observes push/rx_data/pe/fe/bi/busy.
// slave : the receiver itself.
interface uart_rx_if;
    logic       baud_pulse;
    logic       rx;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       push;
    logic [7:0] rx_data;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       busy;

    modport master (
        output baud_pulse, rx, wls, pen, eps, sp,
        input  push, rx_data, pe, fe, bi, busy
    );

    modport slave (
        input  baud_pulse, rx, wls, pen, eps, sp,
        output push, rx_data, pe, fe, bi, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the async rx line plus falling-edge detect.
// Latency: rx_s lags rx by SYNC_STAGES clk; rx_fall is combinational on rx_s.
// Backpressure: none.
//
// Ports: clk, rst (sync, active-low), rx (async in), rx_s (synchronized level),
//        rx_fall (high for one clk when rx_s goes 1 -> 0).
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s_q;

    // Flops reset to 1 so an idle line does not look like a start edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rx_s_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_s_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 16550-style UART receiver: deframes start/data/parity/stop from the oversampled rx line.
// Latency: start seen SYNC_STAGES+1 clk after rx falls; push 1 clk after the stop-bit sample tick.
// Backpressure: none; push is a one-cycle strobe the receive FIFO must accept.
//
// Ports: clk, rst (sync, active-low), bus (uart_rx_if.slave):
//   baud_pulse/rx/wls/pen/eps/sp in; push/rx_data/pe/fe/bi/busy out.
// OVS must be even and >= 4.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS         = OVS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int             TW       = $clog2(OVS);
    localparam logic [TW-1:0]  TICK_MID = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]  TICK_END = TW'(OVS - 1);

    rx_state_t     state;
    rx_state_t     state_nxt;

    logic          rx_s;
    logic          rx_fall;

    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    last_bit;
    logic [7:0]    shift_q;

    // LCR snapshot taken when a frame starts.
    logic [3:0]    nbits_q;
    logic          pen_q;
    logic          eps_q;
    logic          sp_q;

    logic          par_q;     // sampled parity bit
    logic          pe_q;      // parity result pending until the stop bit
    logic          brk;

    logic          push_q;
    logic [7:0]    rx_data_q;
    logic          pe_o;
    logic          fe_o;
    logic          bi_o;

    // Control strobes from the FSM.
    logic          frame_start;
    logic          tick_clr;
    logic          tick_inc;
    logic          bit_clr;
    logic          bit_inc;
    logic          data_smp;
    logic          par_smp;
    logic          stop_smp;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (bus.rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign last_bit = 3'(nbits_q - 4'd1);

    // A break is an all-zero frame: every data bit, the parity bit when
    // enabled, and the stop bit itself.
    assign brk = (shift_q == 8'h00) && !(pen_q && par_q) && !rx_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        tick_clr    = 1'b0;
        tick_inc    = 1'b0;
        bit_clr     = 1'b0;
        bit_inc     = 1'b0;
        data_smp    = 1'b0;
        par_smp     = 1'b0;
        stop_smp    = 1'b0;

        case (state)
            IDLE: begin
                tick_clr = 1'b1;
                // Only an edge starts a frame, so a line stuck low after a
                // break cannot retrigger reception.
                if (rx_fall) begin
                    state_nxt   = START;
                    frame_start = 1'b1;
                end
            end

            START: begin
                if (bus.baud_pulse) begin
                    if (tick_cnt == TICK_MID) begin
                        tick_clr = 1'b1;
                        if (rx_s) begin
                            state_nxt = IDLE;   // glitch, not a start bit
                        end else begin
                            bit_clr   = 1'b1;
                            state_nxt = DATA;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end

            DATA: begin
                if (bus.baud_pulse) begin
                    if (tick_cnt == TICK_END) begin
                        tick_clr = 1'b1;
                        data_smp = 1'b1;
                        if (bit_cnt == last_bit) begin
                            state_nxt = pen_q ? PARITY : STOP;
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end

            PARITY: begin
                if (bus.baud_pulse) begin
                    if (tick_cnt == TICK_END) begin
                        tick_clr  = 1'b1;
                        par_smp   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end

            STOP: begin
                if (bus.baud_pulse) begin
                    if (tick_cnt == TICK_END) begin
                        // Finish at stop-bit mid-point so a following start
                        // bit with no idle gap is still caught.
                        tick_clr  = 1'b1;
                        stop_smp  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            nbits_q   <= 4'd5;
            pen_q     <= 1'b0;
            eps_q     <= 1'b0;
            sp_q      <= 1'b0;
            par_q     <= 1'b0;
            pe_q      <= 1'b0;
            push_q    <= 1'b0;
            rx_data_q <= '0;
            pe_o      <= 1'b0;
            fe_o      <= 1'b0;
            bi_o      <= 1'b0;
        end else begin
            if (tick_clr) begin
                tick_cnt <= '0;
            end else if (tick_inc) begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Clearing the shifter here keeps unused upper bits at 0 for
            // short word lengths.
            if (frame_start) begin
                shift_q <= '0;
                nbits_q <= data_bits(bus.wls);
                pen_q   <= bus.pen;
                eps_q   <= bus.eps;
                sp_q    <= bus.sp;
                par_q   <= 1'b0;
                pe_q    <= 1'b0;
            end

            if (data_smp) begin
                shift_q[bit_cnt] <= rx_s;
            end

            if (par_smp) begin
                par_q <= rx_s;
                pe_q  <= (rx_s != parity_expected(shift_q, nbits_q, eps_q, sp_q));
            end

            push_q <= stop_smp;
            if (stop_smp) begin
                rx_data_q <= brk ? 8'h00 : shift_q;
                pe_o      <= pe_q;
                fe_o      <= ~rx_s;
                bi_o      <= brk;
            end
        end
    end

    assign bus.push    = push_q;
    assign bus.rx_data = rx_data_q;
    assign bus.pe      = pe_o;
    assign bus.fe      = fe_o;
    assign bus.bi      = bi_o;
    // The push cycle is already back in IDLE, so fold push into busy.
    assign bus.busy    = (state != IDLE) || push_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx with a queue scoreboard and a frame-level model.
// Latency: baud_pulse every 4 clk, one bit = 64 clk.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .OVS         (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    logic prev_push = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Parity bit a correct transmitter would send.
    function automatic logic ref_parity(input logic [7:0] d, input int nbits,
                                        input logic eps, input logic sp);
        int ones;
        ones = $countones(d & 8'((1 << nbits) - 1));
        if (sp) return !eps;
        if (eps) return (ones % 2) == 1;
        return (ones % 2) == 0;
    endfunction

    // Expected receiver report for a frame as put on the line.
    function automatic exp_t model(input logic [7:0] data, input int nbits, input logic pen,
                                   input logic eps, input logic sp, input logic par_bit,
                                   input logic stop_bit);
        exp_t e;
        logic [7:0] d;
        d      = data & 8'((1 << nbits) - 1);
        e.bi   = (d == 8'h00) && (!pen || !par_bit) && !stop_bit;
        e.data = e.bi ? 8'h00 : d;
        e.pe   = pen && (par_bit != ref_parity(d, nbits, eps, sp));
        e.fe   = !stop_bit;
        return e;
    endfunction

    task automatic bit_time(input logic b);
        bus.rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                              input logic eps, input logic sp, input logic par_bit,
                              input logic stop_bit, input logic scramble);
        exp_q.push_back(model(data, nbits, pen, eps, sp, par_bit, stop_bit));
        bus.wls = 2'(nbits - 5);
        bus.pen = pen;
        bus.eps = eps;
        bus.sp  = sp;
        bit_time(1'b0);
        if (scramble) begin
            bus.wls = 2'($urandom);
            bus.pen = 1'($urandom);
            bus.eps = 1'($urandom);
            bus.sp  = 1'($urandom);
        end
        for (int i = 0; i < nbits; i++) bit_time(data[i]);
        if (pen) bit_time(par_bit);
        bit_time(stop_bit);
        bus.rx = 1'b1;
    endtask

    // Baud tick generator.
    initial begin
        bus.baud_pulse = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.baud_pulse = 1'b1;
            @(negedge clk);
            bus.baud_pulse = 1'b0;
        end
    end

    // Monitor: every push pops one expectation.
    always @(negedge clk) begin
        if (rst && bus.push) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: actual data %02h pe %0b fe %0b bi %0b, required no push",
                         bus.rx_data, bus.pe, bus.fe, bus.bi);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", 32'(bus.rx_data), 32'(mon_e.data));
                check("pe", 32'(bus.pe), 32'(mon_e.pe));
                check("fe", 32'(bus.fe), 32'(mon_e.fe));
                check("bi", 32'(bus.bi), 32'(mon_e.bi));
                check("busy_in_push", 32'(bus.busy), 32'd1);
            end
        end
        if (rst && prev_push) check("push_width", 32'(bus.push), 32'd0);
        prev_push = rst && bus.push;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         nb;
        logic       pn, ep, s, pb, sb;

        rst     = 1'b0;
        bus.rx  = 1'b1;
        bus.wls = 2'b11;
        bus.pen = 1'b0;
        bus.eps = 1'b0;
        bus.sp  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_push", 32'(bus.push), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_pe", 32'(bus.pe), 32'd0);
        check("rst_fe", 32'(bus.fe), 32'd0);
        check("rst_bi", 32'(bus.bi), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        bit_time(1'b1);

        // Glitch of a quarter bit: start seen after SYNC_STAGES+1 clk, then rejected.
        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        check("start_latency_early", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("start_latency", 32'(bus.busy), 32'd1);
        repeat (BIT_CLK / 4 - 3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_busy", 32'(bus.busy), 32'd0);

        // 5-bit odd parity, 0x10, parity bit 0.
        send_frame(8'h10, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bit_time(1'b1);
        // 8N1 back-to-back, LCR scrambled mid-frame on the first.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // 8-bit even parity with the wrong parity bit.
        send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        // Stick parity, eps=1, 7-bit: bit 0 is correct, bit 1 is not.
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        bit_time(1'b1);

        // Break: line low for three 8N1 frame times.
        bus.wls = 2'b11;
        bus.pen = 1'b0;
        exp_q.push_back(model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.rx = 1'b0;
        repeat (3 * 10 * BIT_CLK) @(negedge clk);
        bus.rx = 1'b1;
        bit_time(1'b1);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bit_time(1'b1);

        // Reset in the middle of the data bits.
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_push", 32'(bus.push), 32'd0);
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (10 * BIT_CLK) @(negedge clk);

        // Random frames.
        for (int n = 0; n < 40; n++) begin
            d  = 8'($urandom);
            nb = 5 + int'($urandom % 4);
            pn = 1'($urandom);
            ep = 1'($urandom);
            s  = 1'($urandom);
            if (n % 10 == 0) d = 8'h00;
            pb = ref_parity(d, nb, ep, s) ^ (($urandom % 4) == 0);
            sb = ($urandom % 6) != 0;
            if (n % 10 == 0) begin
                pb = 1'b0;
                sb = 1'b0;
            end
            send_frame(d, nb, pn, ep, s, pb, sb, ($urandom % 3) == 0);
            if (!sb || ($urandom % 2) == 1) bit_time(1'b1);
        end

        bit_time(1'b1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive path of the 16550-compatible UART, the counterpart of the transmitter `uart_tx`. Samples the serial `rx` line on the shared 16x baud tick and deframes start, data, optional parity and stop bits according to the LCR fields. Delivers each received character with its error flags as a one-cycle push into the receive FIFO.

## Interface
Parameters:
- `OVS`, 16: baud ticks per bit. Must be an even number ≥ 4.
- `SYNC_STAGES`, 2: number of flops in the `rx` metastability synchronizer.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous, active-low.
- `baud_pulse` in 1: 16x oversample tick from the divisor-latch baud generator. Single-cycle pulse.
- `rx` in 1: serial line, asynchronous. Idles high.
- `wls` in 2: word length select. Data bits = 5 + `wls`.
- `pen` in 1: parity enable.
- `eps` in 1: even parity select. 1 = even, 0 = odd.
- `sp` in 1: stick parity.
- `push` out 1: one-cycle strobe. `rx_data`, `pe`, `fe` and `bi` are valid in this cycle.
- `rx_data` out 8: received character, right-aligned. Unused upper bits are 0.
- `pe` out 1: parity error.
- `fe` out 1: framing error.
- `bi` out 1: break indication.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- `rx` passes through the synchronizer. A falling edge on the synchronized line is detected as the start condition. A level-low line alone never starts a frame.
- States: IDLE → START → DATA → (PARITY if `pen`) → STOP → IDLE.
- IDLE:
  - Tick counter is held at 0.
  - On a synchronized falling edge, go to START.
- START:
  - Count `baud_pulse` ticks.
  - At tick `OVS/2 - 1`, sample the line.
  - If the sample is high, treat it as a glitch and return to IDLE with no push.
  - If the sample is low, reset the tick and bit counters and go to DATA.
- DATA:
  - Sample every `OVS` ticks at mid-bit. Data arrives LSB first.
  - Shift the sample into bit position `bit_cnt`.
  - After 5 + `wls` bits, go to PARITY if `pen`, otherwise go to STOP.
- PARITY:
  - Sample the parity bit.
  - Expected value:
    - `sp` = 0: even/odd parity of the data bits per `eps`.
    - `sp` = 1: ~`eps` (stick 1 when `eps` = 0, stick 0 when `eps` = 1).
  - `pe` is set when the sample ≠ the expected value.
- STOP:
  - Sample the first stop bit only. The second stop bit is not checked.
  - `fe` = ~sample.
  - `bi` = 1 when all data bits, the parity bit (if enabled) and the stop bit were all 0. In that case `rx_data` = 0 and `fe` = 1.
  - Assert `push`, then go to IDLE.
- After a break or framing error, the next frame needs a fresh high→low edge. A line held low does not retrigger reception.
- LCR fields are latched when leaving IDLE. Changes made mid-frame take effect on the next frame.
- Errors are reported per character only. There is no overrun handling here; that belongs to the FIFO/LSR.

## Timing
- Reset values: `push` = 0, `rx_data` = 0x00, `pe` = 0, `fe` = 0, `bi` = 0, `busy` = 0. State = IDLE, counters = 0, synchronizer flops = 1.
- Edge-detect latency: the start condition is recognized `SYNC_STAGES` + 1 clk after `rx` falls.
- `push` rises in the clk cycle after the `baud_pulse` that samples the stop bit, and lasts exactly 1 clk.
- `rx_data`, `pe`, `fe` and `bi` hold their values until the next `push`.
- The frame completes half a bit early, at stop-bit mid-point. This allows back-to-back frames with no idle gap.
- `busy` is high from the START entry cycle through the `push` cycle inclusive.
- Counters advance only on `baud_pulse`. With no ticks, the block stalls in place.
- A reset asserted mid-frame returns to IDLE on the next edge with no `push`. The partial character is discarded.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP}.
  - `OVS_DEFAULT` = 16.
  - `wls` encoding constants.
  - Function `parity_expected(data, nbits, eps, sp)`, also used by `uart_tx`.
- Sub-module `uart_rx_sync`: `SYNC_STAGES` flop chain plus falling-edge detect. Its outputs are `rx_s` and `rx_fall`.

## Test plan
Bench drives `baud_pulse` every 4 clk, so 1 bit = 64 clk.
- 5-bit frame, odd parity, `wls` = 00, `pen` = 1, `eps` = 0, `sp` = 0. Line sends data 10000b (value 0x10) with parity bit 0 and 1 stop bit. Required: one `push`, `rx_data` = 0x10, `pe` = 0, `fe` = 0, `bi` = 0.
- 8-bit, no parity, `wls` = 11. Line sends 0xA5 immediately followed by 0x3C with no idle gap. Required: two `push` strobes, 0xA5 then 0x3C, all flags 0.
- 8-bit, even parity, `sp` = 0. Line sends 0x01 with parity bit 0 (wrong value). Required: `rx_data` = 0x01, `pe` = 1.
- Stick parity, `sp` = 1, `eps` = 1, 7-bit. Line sends 0x55 with parity bit 0. Required: `pe` = 0. Repeat with parity bit 1: required `pe` = 1.
- Line held low for 3 frame times, then returned high. Required: exactly one `push` with `rx_data` = 0x00, `bi` = 1, `fe` = 1. A second frame sent afterwards decodes correctly.
- Other boundary cases:
  - A 1-bit-time/4 low glitch on `rx`: required, no `push`.
  - `rst` pulled low while in DATA: required, no `push` and `busy` = 0 on the next clk.
